// File: rtl/watch_pkg.sv
// Shared mode and stopwatch-state encodings for the watch controller, stopwatch and display blocks.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'b00,
    MODE_STOPWATCH = 2'b01,
    MODE_TIMER     = 2'b10,
    MODE_ALARM     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SW_IDLE    = 2'b00,
    SW_RUNNING = 2'b01,
    SW_PAUSED  = 2'b10
  } sw_state_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK:     next_mode = MODE_STOPWATCH;
      MODE_STOPWATCH: next_mode = MODE_TIMER;
      MODE_TIMER:     next_mode = MODE_ALARM;
      MODE_ALARM:     next_mode = MODE_CLOCK;
      default:        next_mode = MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_if.sv
// Button inputs and mode/stopwatch outputs of the watch mode controller.
interface watch_mode_ctrl_if;
  import watch_pkg::*;

  logic      btn_mode;
  logic      btn_start;
  logic      btn_clear;
  mode_e     sel;
  logic      sw_run;
  logic      sw_clear;
  sw_state_e sw_state;

  modport master (
    output btn_mode, btn_start, btn_clear,
    input  sel, sw_run, sw_clear, sw_state
  );

  modport slave (
    input  btn_mode, btn_start, btn_clear,
    output sel, sw_run, sw_clear, sw_state
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for one raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk100MHz,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips only after a full run of samples disagreeing with it; any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode selector and stopwatch start/pause/clear FSM driven by three debounced buttons.
// Optional feature macro: WATCH_LONG_PRESS_EN (long start hold clears the stopwatch).
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 200000000
) (
  input logic               clk100MHz,
  input logic               rst_n,
  watch_mode_ctrl_if.slave  bus
);

  logic mode_lvl_s, start_lvl_s, clear_lvl_s;
  logic mode_press_s, start_press_s, clear_press_s;
  logic sw_sel_s, start_ev_s, clear_ev_s, long_ev_s;
  logic unused_s;

  sw_state_e state_q, state_d;
  mode_e     sel_q, sel_d;
  logic      sw_run_q, sw_run_d;
  logic      sw_clear_q, sw_clear_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk100MHz(clk100MHz), .rst_n(rst_n), .btn_i(bus.btn_mode),
    .level_o(mode_lvl_s), .press_o(mode_press_s));

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk100MHz(clk100MHz), .rst_n(rst_n), .btn_i(bus.btn_start),
    .level_o(start_lvl_s), .press_o(start_press_s));

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk100MHz(clk100MHz), .rst_n(rst_n), .btn_i(bus.btn_clear),
    .level_o(clear_lvl_s), .press_o(clear_press_s));

  // Start/clear are judged against the mode in force before a same-cycle mode step.
  assign sw_sel_s   = (sel_q == MODE_STOPWATCH);
  assign start_ev_s = start_press_s & sw_sel_s;
  assign clear_ev_s = clear_press_s & sw_sel_s;

`ifdef WATCH_LONG_PRESS_EN
  localparam int              LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_ZERO = LP_W'(0);
  localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;

  // Hold-time counter saturates past the trigger point so one hold fires once.
  always_comb begin
    if (!start_lvl_s) begin
      lp_cnt_d = LP_ZERO;
    end else if (lp_cnt_q != LP_SAT) begin
      lp_cnt_d = lp_cnt_q + LP_ONE;
    end else begin
      lp_cnt_d = lp_cnt_q;
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt_q <= LP_ZERO;
    end else begin
      lp_cnt_q <= lp_cnt_d;
    end
  end

  assign long_ev_s = start_lvl_s & (lp_cnt_q == LP_LAST) & sw_sel_s;
  assign unused_s  = ^{mode_lvl_s, clear_lvl_s};
`else
  assign long_ev_s = 1'b0;
  assign unused_s  = ^{mode_lvl_s, clear_lvl_s, start_lvl_s} ^ LONG_PRESS_CYCLES[0];
`endif

  // State register: FSM state, mode select and registered outputs.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SW_IDLE;
      sel_q      <= MODE_CLOCK;
      sw_run_q   <= 1'b0;
      sw_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sw_run_q   <= sw_run_d;
      sw_clear_q <= sw_clear_d;
    end
  end

  // Next-state logic: clear (or long hold) beats start.
  always_comb begin
    state_d = state_q;
    if (clear_ev_s || long_ev_s) begin
      state_d = SW_IDLE;
    end else if (start_ev_s) begin
      case (state_q)
        SW_IDLE:    state_d = SW_RUNNING;
        SW_RUNNING: state_d = SW_PAUSED;
        SW_PAUSED:  state_d = SW_RUNNING;
        default:    state_d = SW_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic, computed from the next state so outputs move with the state.
  always_comb begin
    sel_d      = mode_press_s ? next_mode(sel_q) : sel_q;
    sw_run_d   = (state_d == SW_RUNNING);
    sw_clear_d = clear_ev_s | long_ev_s;
  end

  assign bus.sel      = sel_q;
  assign bus.sw_state = state_q;
  assign bus.sw_run   = sw_run_q;
  assign bus.sw_clear = sw_clear_q;

endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: clk100MHz cycles a raw button must hold stable before its debounced level changes (10 ms).
REQ-002 Parameter LONG_PRESS_CYCLES, default 200000000: debounced-high cycles of btn_start that count as a long press (2 s).
REQ-003 clk100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn_mode  input  1  raw, asynchronous mode button, active-high.
REQ-006 btn_start  input  1  raw, asynchronous start/pause button, active-high.
REQ-007 btn_clear  input  1  raw, asynchronous clear button, active-high.
REQ-008 sel  output  2  mode select: 00 CLOCK, 01 STOPWATCH, 10 TIMER, 11 ALARM.
REQ-009 sw_run  output  1  level; stopwatch counts while high.
REQ-010 sw_clear  output  1  one-cycle pulse; zeroes stopwatch digits.
REQ-011 sw_state  output  2  stopwatch state for display/debug: 00 IDLE, 01 RUNNING, 10 PAUSED.

Function
REQ-012 Each button passes a 2-flop synchronizer, then a debouncer; the debounced level toggles only after DEBOUNCE_CYCLES consecutive samples at the new level.
REQ-013 A press event is a one-cycle pulse on the debounced 0->1 edge; release generates no event.
REQ-014 A mode press advances sel 00->01->10->11->00, one step per press, updating the cycle after the press event.
REQ-015 Stopwatch FSM: IDLE --start (sel=01)--> RUNNING; RUNNING --start--> PAUSED; PAUSED --start--> RUNNING; RUNNING/PAUSED --clear (sel=01)--> IDLE; IDLE --clear--> IDLE.
REQ-016 sw_run = 1 exactly when sw_state = RUNNING, registered, same cycle as the state change.
REQ-017 sw_clear pulses for exactly one cycle on every clear press accepted in sel=01, including from IDLE.
REQ-018 Start and clear presses while sel != 01 are ignored; the stopwatch FSM holds its state and sw_run keeps its value, so a running stopwatch keeps running in other modes.
REQ-019 Clear and start press events in the same cycle: clear wins; next state IDLE, sw_run=0, sw_clear pulses.
REQ-020 Mode and start/clear press events in the same cycle: start/clear is evaluated against the pre-update sel, then sel advances.
REQ-021 Latency from raw button stable edge to output change is DEBOUNCE_CYCLES+3 cycles (±1).

Reset
REQ-022 While rst_n=0: sel=00, sw_state=IDLE, sw_run=0, sw_clear=0, all debounce counters and synchronizers 0, long-press counter 0.
REQ-023 Reset asserted mid-press discards the press; after release of rst_n, a held button must be re-debounced from zero before it is recognised.

Configuration
REQ-024 Macro WATCH_LONG_PRESS_EN: when defined, btn_start held debounced-high for LONG_PRESS_CYCLES in sel=01 emits sw_clear for one cycle and forces IDLE (once per hold); the initial short-press transition still occurs on the press edge.
REQ-025 Without WATCH_LONG_PRESS_EN, the long-press counter is not built, LONG_PRESS_CYCLES is unused, and holding btn_start has no effect beyond the single press event.

Structure
REQ-026 Package watch_pkg holds the sel mode encoding typedef (MODE_CLOCK/STOPWATCH/TIMER/ALARM) and the stopwatch state typedef (SW_IDLE/RUNNING/PAUSED), shared with the stopwatch and display blocks.
REQ-027 Sub-module btn_debounce (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES) is instantiated three times; FSM and long-press logic stay in watch_mode_ctrl.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50)
REQ-028 Mode cycling: 5 clean btn_mode presses from reset -> sel 01,10,11,00,01.
REQ-029 Bounce: btn_start toggling every 2 cycles for 20 cycles then high, sel=01 -> exactly one IDLE->RUNNING transition, sw_run=1.
REQ-030 Start/pause/clear: in sel=01 press start, start, start, clear -> sw_state 01,10,01,00; sw_clear high one cycle on the final press.
REQ-031 Mode isolation: RUNNING, switch to sel=10, press start and clear -> sw_run stays 1, no sw_clear; return to 01 -> still RUNNING.
REQ-032 Simultaneous start+clear edges in sel=01 while PAUSED -> IDLE, one sw_clear pulse, sw_run=0.
REQ-033 Reset mid-run, and (WATCH_LONG_PRESS_EN) hold start 60 cycles in RUNNING -> rst_n low gives all REQ-022 values; long hold gives one sw_clear pulse and IDLE.
